// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// jellyvl_etherneco_synctimer_pkg: shared types, register map and byte-masked write helper
package jellyvl_etherneco_synctimer_pkg;
  typedef logic [63:0]        t_time;
  typedef logic signed [39:0] t_adj_value;

  localparam logic [31:0] CORE_ID        = 32'hffff1123;
  localparam logic [31:0] ADR_CORE_ID    = 32'h00;
  localparam logic [31:0] ADR_CTL        = 32'h10;
  localparam logic [31:0] ADR_OVERRIDE   = 32'h11;
  localparam logic [31:0] ADR_PERIOD_MIN = 32'h12;
  localparam logic [31:0] ADR_TIME_LO    = 32'h14;
  localparam logic [31:0] ADR_TIME_HI    = 32'h15;
  localparam logic [31:0] ADR_SET_LO     = 32'h16;
  localparam logic [31:0] ADR_SET_HI     = 32'h17;
  localparam logic [31:0] ADR_ADJ_COUNT  = 32'h18;
  localparam logic [31:0] TRIG_BASE      = 32'h40;
  localparam logic [31:0] TRIG_STRIDE    = 32'h4;

  function automatic logic [31:0] wmask(input logic [31:0] cur, input logic [31:0] dat, input logic [3:0] sel);
    for (int b = 0; b < 4; b++) if (sel[b]) cur[b*8 +: 8] = dat[b*8 +: 8];
    return cur;
  endfunction
endpackage

// File: rtl/jellyvl_etherneco_synctimer_trigger.sv
// jellyvl_etherneco_synctimer_trigger: one compare channel with wrap-safe crossing detect and reload
module jellyvl_etherneco_synctimer_trigger
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH = 64
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [1:0]             ofs,
  input  logic [31:0]            wr_dat,
  input  logic [3:0]             wr_sel,
  output logic [31:0]            rd_dat,
  input  logic [TIMER_WIDTH-1:0] prev_time,
  input  logic [TIMER_WIDTH-1:0] cur_time,
  output logic                   trig
);
  localparam logic signed [TIMER_WIDTH-1:0] ZERO = '0;

  logic                          en, periodic, fire, wr_ctl, wr_cmp;
  logic [TIMER_WIDTH-1:0]        cmp;
  logic signed [TIMER_WIDTH-1:0] d_cur, d_prev;
  logic [31:0]                   period;
  t_time                         cmp_ext, cmp_new;

  // signed distance makes the crossing test immune to timer wrap and multi-unit steps
  always_comb begin
    d_cur   = cur_time - cmp;
    d_prev  = prev_time - cmp;
    fire    = en && d_cur >= ZERO && d_prev < ZERO;
    wr_ctl  = wr_en && ofs == 2'd0;
    wr_cmp  = wr_en && (ofs == 2'd1 || ofs == 2'd2);
    cmp_ext = 64'(cmp);
    cmp_new = {wr_en && ofs == 2'd2 ? wmask(cmp_ext[63:32], wr_dat, wr_sel) : cmp_ext[63:32],
               wr_en && ofs == 2'd1 ? wmask(cmp_ext[31:0], wr_dat, wr_sel) : cmp_ext[31:0]};
    rd_dat  = ofs == 2'd0 ? {30'd0, periodic, en} :
              ofs == 2'd1 ? cmp_ext[31:0] :
              ofs == 2'd2 ? cmp_ext[63:32] : period;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      cmp      <= '0;
      period   <= '0;
      trig     <= 1'b0;
    end else begin
      trig <= fire;
      if (fire && !wr_ctl && !wr_cmp) begin
        if (periodic && period != '0) cmp <= cmp + TIMER_WIDTH'(period);
        else en <= 1'b0;
      end
      if (wr_ctl && wr_sel[0]) {periodic, en} <= wr_dat[1:0];
      if (wr_cmp) cmp <= TIMER_WIDTH'(cmp_new);
      if (wr_en && ofs == 2'd3) period <= wmask(period, wr_dat, wr_sel);
    end
  end
endmodule

// File: rtl/jellyvl_etherneco_synctimer_adjtimer.sv
// jellyvl_etherneco_synctimer_adjtimer: fractional-rate local timer with period-based +/-1 correction,
// load, snapshot read and compare triggers behind a Wishbone register file
module jellyvl_etherneco_synctimer_adjtimer
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH     = 64,
  parameter int NUMERATOR       = 10,
  parameter int DENOMINATOR     = 3,
  parameter int ADJ_WIDTH       = 32,
  parameter int ADJ_Q           = 8,
  parameter int TRIG_NUM        = 2,
  parameter int WB_ADR_WIDTH    = 16,
  parameter int WB_DAT_WIDTH    = 32,
  parameter int INIT_PERIOD_MIN = 16
) (
  input  logic                              reset,
  input  logic                              clk,
  input  logic [WB_ADR_WIDTH-1:0]           s_wb_adr_i,
  output logic [WB_DAT_WIDTH-1:0]           s_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0]           s_wb_dat_i,
  input  logic [WB_DAT_WIDTH/8-1:0]         s_wb_sel_i,
  input  logic                              s_wb_we_i,
  input  logic                              s_wb_stb_i,
  output logic                              s_wb_ack_o,
  input  logic                              adj_enable,
  input  logic signed [ADJ_WIDTH+ADJ_Q-1:0] adj_value,
  input  logic                              set_valid,
  input  logic [TIMER_WIDTH-1:0]            set_time,
  output logic [TIMER_WIDTH-1:0]            current_time,
  output logic [TRIG_NUM-1:0]               trig_out
);
  localparam int TW = TIMER_WIDTH;
  localparam int PW = ADJ_WIDTH + ADJ_Q;
  localparam int AW = (ADJ_WIDTH > 32 ? ADJ_WIDTH : 32) + ADJ_Q + 1;
  localparam int FW = $clog2(DENOMINATOR) + 1;

  logic [31:0]          adr, override_value, period_min, set_lo, set_hi, set_hi_new, adj_count, trig_idx, trig_rd;
  logic                 wr, wr_set_hi, trig_hit, override_en, neg_prev, p_neg, carry, adj_hit, load;
  logic [TW-1:0]        prev_time, time_next, load_time, adj_step;
  logic [TW-33:0]       snap_hi;
  logic [FW-1:0]        frac, frac_add;
  logic signed [PW-1:0] p;
  logic [AW-1:0]        p_ext, p_abs, p_min, p_lim, cnt, cnt_add, cnt_next;
  logic [31:0]          ch_rd [TRIG_NUM];

  assign adr        = 32'(s_wb_adr_i);
  assign wr         = s_wb_stb_i && s_wb_we_i;
  assign wr_set_hi  = wr && adr == ADR_SET_HI;
  assign s_wb_ack_o = s_wb_stb_i;
  assign trig_hit   = adr >= TRIG_BASE && adr < TRIG_BASE + TRIG_STRIDE * 32'(TRIG_NUM);
  assign trig_idx   = (adr - TRIG_BASE) / TRIG_STRIDE;

  // cnt accumulates in Q(ADJ_Q) and a +/-1 is emitted each time it passes |P|
  always_comb begin
    frac_add   = frac + FW'(NUMERATOR % DENOMINATOR);
    carry      = frac_add >= FW'(DENOMINATOR);
    p          = override_en ? PW'($signed(override_value)) : adj_enable ? adj_value : '0;
    p_neg      = p[PW-1];
    p_ext      = AW'(p);
    p_abs      = p_neg ? -p_ext : p_ext;
    p_min      = AW'({period_min, {ADJ_Q{1'b0}}});
    p_lim      = (p != '0 && p_abs < p_min) ? p_min : p_abs;
    cnt_add    = (p_neg != neg_prev ? '0 : cnt) + (AW'(1) << ADJ_Q);
    adj_hit    = p != '0 && cnt_add >= p_lim;
    cnt_next   = p == '0 ? '0 : adj_hit ? cnt_add - p_lim : cnt_add;
    adj_step   = adj_hit ? (p_neg ? '1 : TW'(1)) : '0;
    time_next  = current_time + TW'(NUMERATOR / DENOMINATOR) + TW'(carry) + adj_step;
    set_hi_new = wmask(set_hi, s_wb_dat_i, s_wb_sel_i);
    load       = set_valid || wr_set_hi;
    load_time  = set_valid ? set_time : TW'(t_time'({set_hi_new, set_lo}));
  end

  always_comb begin
    trig_rd = '0;
    for (int k = 0; k < TRIG_NUM; k++) if (trig_idx == 32'(k)) trig_rd = ch_rd[k];
    case (adr)
      ADR_CORE_ID:    s_wb_dat_o = CORE_ID;
      ADR_CTL:        s_wb_dat_o = {31'd0, override_en};
      ADR_OVERRIDE:   s_wb_dat_o = override_value;
      ADR_PERIOD_MIN: s_wb_dat_o = period_min;
      ADR_TIME_LO:    s_wb_dat_o = current_time[31:0];
      ADR_TIME_HI:    s_wb_dat_o = 32'(snap_hi);
      ADR_ADJ_COUNT:  s_wb_dat_o = adj_count;
      default:        s_wb_dat_o = trig_hit ? trig_rd : '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_time   <= '0;
      prev_time      <= '0;
      frac           <= '0;
      cnt            <= '0;
      neg_prev       <= 1'b0;
      adj_count      <= '0;
      snap_hi        <= '0;
      override_en    <= 1'b0;
      override_value <= '0;
      period_min     <= 32'(INIT_PERIOD_MIN);
      set_lo         <= '0;
      set_hi         <= '0;
    end else begin
      prev_time    <= current_time;
      current_time <= load ? load_time : time_next;
      frac         <= load ? '0 : carry ? frac_add - FW'(DENOMINATOR) : frac_add;
      cnt          <= load ? '0 : cnt_next;
      neg_prev     <= p_neg;
      if (adj_hit && !load) adj_count <= adj_count + 32'd1;
      if (s_wb_stb_i && !s_wb_we_i && adr == ADR_TIME_LO) snap_hi <= current_time[TW-1:32];
      if (wr && adr == ADR_CTL && s_wb_sel_i[0]) override_en <= s_wb_dat_i[0];
      if (wr && adr == ADR_OVERRIDE) override_value <= wmask(override_value, s_wb_dat_i, s_wb_sel_i);
      if (wr && adr == ADR_PERIOD_MIN) period_min <= wmask(period_min, s_wb_dat_i, s_wb_sel_i);
      if (wr && adr == ADR_SET_LO) set_lo <= wmask(set_lo, s_wb_dat_i, s_wb_sel_i);
      if (wr_set_hi) set_hi <= set_hi_new;
    end
  end

  for (genvar i = 0; i < TRIG_NUM; i++) begin : g_trig
    jellyvl_etherneco_synctimer_trigger #(
      .TIMER_WIDTH(TW)
    ) u_trig (
      .reset    (reset),
      .clk      (clk),
      .wr_en    (wr && trig_hit && trig_idx == 32'(i)),
      .ofs      (adr[1:0]),
      .wr_dat   (s_wb_dat_i),
      .wr_sel   (s_wb_sel_i),
      .rd_dat   (ch_rd[i]),
      .prev_time(prev_time),
      .cur_time (current_time),
      .trig     (trig_out[i])
    );
  end
endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_adjtimer.sv
// tb_jellyvl_etherneco_synctimer_adjtimer: register-table vectors plus directed timer/adjust/trigger sequences
module tb_jellyvl_etherneco_synctimer_adjtimer;
  import jellyvl_etherneco_synctimer_pkg::*;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  logic        reset = 1'b1, clk = 1'b0;
  logic [15:0] adr = '0;
  logic [31:0] dat_o, dat_i = '0, r;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, stb = 1'b0, ack;
  logic        adj_enable = 1'b0, set_valid = 1'b0;
  t_adj_value  adj_value = '0;
  t_time       set_time = '0, current_time;
  logic [1:0]  trig_out;
  int          n_chk = 0, n_pass = 0, bad, pulses;
  t_time       pulse_t[$];
  vec_t        vt[15];

  always #5 clk = ~clk;

  jellyvl_etherneco_synctimer_adjtimer dut (
    .reset       (reset),
    .clk         (clk),
    .s_wb_adr_i  (adr),
    .s_wb_dat_o  (dat_o),
    .s_wb_dat_i  (dat_i),
    .s_wb_sel_i  (sel),
    .s_wb_we_i   (we),
    .s_wb_stb_i  (stb),
    .s_wb_ack_o  (ack),
    .adj_enable  (adj_enable),
    .adj_value   (adj_value),
    .set_valid   (set_valid),
    .set_time    (set_time),
    .current_time(current_time),
    .trig_out    (trig_out)
  );

  task automatic check(input string name, input t_time act, input t_time exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wb_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    adr = a; dat_i = d; sel = s; we = 1'b1; stb = 1'b1;
    step(1);
    we = 1'b0; stb = 1'b0;
  endtask

  task automatic wb_read(input logic [15:0] a, output logic [31:0] d);
    adr = a; we = 1'b0; stb = 1'b1;
    #1;
    d = dat_o;
    step(1);
    stb = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'hffff1123};
    vt[1]  = '{1'b0, 16'h0012, 32'h0,        4'h0, 32'd16};
    vt[2]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 32'h0};
    vt[3]  = '{1'b0, 16'h0018, 32'h0,        4'h0, 32'h0};
    vt[4]  = '{1'b0, 16'h0013, 32'h0,        4'h0, 32'h0};
    vt[5]  = '{1'b1, 16'h0011, 32'h12345678, 4'hf, 32'h12345678};
    vt[6]  = '{1'b1, 16'h0011, 32'h000000aa, 4'h1, 32'h123456aa};
    vt[7]  = '{1'b1, 16'h0011, 32'hbb000000, 4'h8, 32'hbb3456aa};
    vt[8]  = '{1'b1, 16'h0010, 32'hffffffff, 4'hf, 32'h1};
    vt[9]  = '{1'b1, 16'h0010, 32'h0,        4'h2, 32'h1};
    vt[10] = '{1'b1, 16'h0010, 32'h0,        4'h1, 32'h0};
    vt[11] = '{1'b1, 16'h0042, 32'hdeadbeef, 4'hf, 32'hdeadbeef};
    vt[12] = '{1'b1, 16'h0047, 32'h00000032, 4'hf, 32'h32};
    vt[13] = '{1'b1, 16'h0048, 32'hffffffff, 4'hf, 32'h0};
    vt[14] = '{1'b1, 16'h0000, 32'h0,        4'hf, 32'hffff1123};

    // reset state and plain 10/3 rate
    do_reset();
    check("reset_time", current_time, 0);
    check("reset_trig", t_time'(trig_out), 0);
    stb = 1'b1; #1;
    check("ack", t_time'(ack), 1);
    stb = 1'b0;
    step(3);
    check("time_3clk", current_time, 10);
    step(297);
    check("time_300clk", current_time, 1000);

    // register map
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (vt[i].we) wb_write(vt[i].adr, vt[i].dat, vt[i].sel);
      wb_read(vt[i].adr, r);
      check($sformatf("reg_vec%0d", i), t_time'(r), t_time'(vt[i].exp));
    end

    // positive and negative correction
    adj_enable = 1'b1;
    adj_value  = 40'sd25600;
    do_reset();
    step(300);
    check("adj_pos_time", current_time, 1003);
    wb_read(16'h0018, r);
    check("adj_pos_count", t_time'(r), 3);
    adj_value = -40'sd25600;
    do_reset();
    step(300);
    check("adj_neg_time", current_time, 997);
    wb_read(16'h0018, r);
    check("adj_neg_count", t_time'(r), 3);

    // PERIOD_MIN floor, then override with zero period
    adj_value = 40'sd1024;
    do_reset();
    step(15);
    check("pmin_15", current_time, 50);
    step(1);
    check("pmin_16", current_time, 54);
    step(32);
    check("pmin_48", current_time, 163);
    wb_read(16'h0018, r);
    check("pmin_count", t_time'(r), 3);
    wb_write(16'h0010, 32'h1, 4'h1);
    step(63);
    check("override_time", current_time, 379);
    wb_read(16'h0018, r);
    check("override_count", t_time'(r), 3);
    adj_enable = 1'b0;
    adj_value  = '0;

    // load priority and wrap
    do_reset();
    wb_write(16'h0016, 32'h5, 4'hf);
    set_valid = 1'b1; set_time = 64'hffff_ffff_ffff_fffe;
    adr = 16'h0017; dat_i = 32'h0; sel = 4'hf; we = 1'b1; stb = 1'b1;
    step(1);
    set_valid = 1'b0; we = 1'b0; stb = 1'b0;
    check("load_port", current_time, 64'hffff_ffff_ffff_fffe);
    step(1);
    check("wrap_1", current_time, 1);
    step(1);
    check("wrap_4", current_time, 4);
    wb_write(16'h0017, 32'h2, 4'hf);
    check("load_wb", current_time, 64'h2_0000_0005);
    step(1);
    check("load_wb_step", current_time, 64'h2_0000_0008);

    // snapshot
    set_valid = 1'b1; set_time = 64'h1_ffff_fffc;
    step(1);
    set_valid = 1'b0;
    wb_read(16'h0014, r);
    check("snap_lo", t_time'(r), 64'hffff_fffc);
    step(4);
    check("snap_live", current_time, 64'h2_0000_000c);
    wb_read(16'h0015, r);
    check("snap_hi", t_time'(r), 1);

    // periodic trigger on channel 0
    do_reset();
    wb_write(16'h0041, 32'd100, 4'hf);
    wb_write(16'h0043, 32'd50, 4'hf);
    wb_write(16'h0040, 32'h3, 4'hf);
    bad = 0;
    for (int c = 0; c < 100 && current_time < 230; c++) begin
      step(1);
      if (trig_out[0]) pulse_t.push_back(current_time);
      if (trig_out[1]) bad++;
    end
    check("per_count", t_time'(pulse_t.size()), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("per_pulse%0d", k), k < pulse_t.size() ? pulse_t[k] : '1, t_time'(103 + 50 * k));
    check("ch1_idle", t_time'(bad), 0);
    wb_read(16'h0041, r);
    check("per_cmp", t_time'(r), 250);

    // one-shot on channel 0
    do_reset();
    wb_write(16'h0041, 32'd7, 4'hf);
    wb_write(16'h0040, 32'h1, 4'hf);
    pulses = 0;
    pulse_t.delete();
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (trig_out[0]) begin pulses++; pulse_t.push_back(current_time); end
    end
    check("oneshot_count", t_time'(pulses), 1);
    check("oneshot_time", pulse_t.size() > 0 ? pulse_t[0] : '1, 13);
    wb_read(16'h0040, r);
    check("oneshot_en", t_time'(r), 0);
    set_valid = 1'b1; set_time = '0;
    step(1);
    set_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (trig_out[0]) pulses++;
    end
    check("disabled_quiet", t_time'(pulses), 1);

    // CTL write in the fire cycle keeps EN as written
    do_reset();
    wb_write(16'h0041, 32'd20, 4'hf);
    wb_write(16'h0040, 32'h1, 4'hf);
    step(4);
    check("fire_cycle_time", current_time, 20);
    wb_write(16'h0040, 32'h1, 4'hf);
    check("fire_wb_trig", t_time'(trig_out[0]), 1);
    wb_read(16'h0040, r);
    check("fire_wb_en", t_time'(r), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
